// File: rtl/val_rdy_queued_demux.sv
// Routes a val/rdy stream to one of p_noutputs channels, each with its own p_depth-entry FIFO; optional macro VAL_RDY_QUEUED_DEMUX_BYPASS_EN.
// Latency: 1 cycle from acceptance to ostream_val (0 cycles into an empty FIFO when the bypass macro is defined).
// Backpressure: istream_rdy drops only when the selected FIFO is registered-full; out-of-range selects are always accepted and flagged.
module val_rdy_queued_demux #(
    parameter int p_nbits    = 32,
    parameter int p_noutputs = 4,
    parameter int p_depth    = 2
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        istream_val,
    output logic                                        istream_rdy,
    input  logic [p_nbits-1:0]                          istream_msg,
    input  logic [$clog2(p_noutputs)-1:0]               istream_sel,
    output logic [p_noutputs-1:0]                       ostream_val,
    input  logic [p_noutputs-1:0]                       ostream_rdy,
    output logic [p_noutputs*p_nbits-1:0]               ostream_msg,
    output logic [p_noutputs*$clog2(p_depth+1)-1:0]     occupancy,
    output logic                                        sel_err
);

    localparam int SW = $clog2(p_noutputs);
    localparam int PW = $clog2(p_depth);
    localparam int CW = $clog2(p_depth + 1);
    localparam logic [SW:0]   NOUT  = (SW + 1)'(p_noutputs);
    localparam logic [CW-1:0] DEPTH = CW'(p_depth);

    logic [p_nbits-1:0] mem   [p_noutputs][p_depth];
    logic [PW-1:0]      head  [p_noutputs];
    logic [PW-1:0]      tail  [p_noutputs];
    logic [CW-1:0]      count [p_noutputs];

    logic [p_noutputs-1:0] full;
    logic [p_noutputs-1:0] empty;
    logic [p_noutputs-1:0] hit;
    logic [p_noutputs-1:0] enq;
    logic [p_noutputs-1:0] deq;
    logic                  sel_ok;
    logic                  xfer;

    // Ready depends only on the select and registered full flags.
    always_comb begin
        sel_ok      = {1'b0, istream_sel} < NOUT;
        istream_rdy = 1'b1;
        full        = '0;
        empty       = '0;
        hit         = '0;
        for (int i = 0; i < p_noutputs; i++) begin
            full[i]  = (count[i] == DEPTH);
            empty[i] = (count[i] == '0);
            hit[i]   = (istream_sel == SW'(i));
            if (hit[i]) istream_rdy = !full[i];
        end
        xfer = istream_val && istream_rdy;
    end

    always_comb begin
        ostream_msg = '0;
        ostream_val = '0;
        occupancy   = '0;
        enq         = '0;
        deq         = '0;
        for (int i = 0; i < p_noutputs; i++) begin
            ostream_msg[i*p_nbits +: p_nbits] = mem[i][head[i]];
            ostream_val[i]                    = !empty[i];
            occupancy[i*CW +: CW]             = count[i];
            enq[i]                            = xfer && hit[i];
            deq[i]                            = !empty[i] && ostream_rdy[i];
`ifdef VAL_RDY_QUEUED_DEMUX_BYPASS_EN
            // Empty FIFO: present the input directly; skip storage if taken now.
            if (empty[i] && istream_val && hit[i]) begin
                ostream_msg[i*p_nbits +: p_nbits] = istream_msg;
                ostream_val[i]                    = 1'b1;
                if (ostream_rdy[i]) enq[i] = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_err <= 1'b0;
            for (int i = 0; i < p_noutputs; i++) begin
                head[i]  <= '0;
                tail[i]  <= '0;
                count[i] <= '0;
            end
        end else begin
            sel_err <= xfer && !sel_ok;
            for (int i = 0; i < p_noutputs; i++) begin
                if (enq[i]) tail[i] <= tail[i] + PW'(1);
                if (deq[i]) head[i] <= head[i] + PW'(1);
                if (enq[i] && !deq[i])      count[i] <= count[i] + CW'(1);
                else if (deq[i] && !enq[i]) count[i] <= count[i] - CW'(1);
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < p_noutputs; i++) begin
            if (enq[i]) mem[i][tail[i]] <= istream_msg;
        end
    end

endmodule

// File: tb/tb_val_rdy_queued_demux.sv
// Bench for val_rdy_queued_demux (3 channels, depth 2): directed scenarios plus random traffic against a queue model.
module tb_val_rdy_queued_demux;
    localparam int NB = 16;
    localparam int NO = 3;
    localparam int D  = 2;
    localparam int SW = 2;
    localparam int CW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              istream_val;
    logic              istream_rdy;
    logic [NB-1:0]     istream_msg;
    logic [SW-1:0]     istream_sel;
    logic [NO-1:0]     ostream_val;
    logic [NO-1:0]     ostream_rdy;
    logic [NO*NB-1:0]  ostream_msg;
    logic [NO*CW-1:0]  occupancy;
    logic              sel_err;

    int n_chk  = 0;
    int n_pass = 0;
    logic [NB-1:0] mq [NO][$];
    logic err_exp = 1'b0;
    logic acc;
    logic tog;

    always #5 clk = ~clk;

    val_rdy_queued_demux #(.p_nbits(NB), .p_noutputs(NO), .p_depth(D)) dut (
        .clk(clk), .reset(reset),
        .istream_val(istream_val), .istream_rdy(istream_rdy),
        .istream_msg(istream_msg), .istream_sel(istream_sel),
        .ostream_val(ostream_val), .ostream_rdy(ostream_rdy),
        .ostream_msg(ostream_msg), .occupancy(occupancy),
        .sel_err(sel_err)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // One clock cycle: drive at the falling edge, compare against the queue model, then advance the model.
    task automatic cycle(input logic v, input int s, input logic [NB-1:0] m,
                         input logic [NO-1:0] r, output logic accepted);
        logic exp_rdy;
        @(negedge clk);
        istream_val = v;
        istream_sel = SW'(s);
        istream_msg = m;
        ostream_rdy = r;
        #1;
        exp_rdy = (s < NO) ? (mq[s].size() < D) : 1'b1;
        chk("istream_rdy", istream_rdy, exp_rdy);
        chk("sel_err", sel_err, err_exp);
        for (int i = 0; i < NO; i++) begin
            chk($sformatf("val%0d", i), ostream_val[i], mq[i].size() != 0);
            chk($sformatf("occ%0d", i), occupancy[i*CW +: CW], mq[i].size());
            if (mq[i].size() != 0)
                chk($sformatf("msg%0d", i), ostream_msg[i*NB +: NB], mq[i][0]);
        end
        accepted = v && exp_rdy;
        for (int i = 0; i < NO; i++)
            if (mq[i].size() != 0 && r[i]) void'(mq[i].pop_front());
        if (accepted && s < NO) mq[s].push_back(m);
        err_exp = accepted && (s >= NO);
    endtask

    task automatic drain();
        logic a;
        repeat (4) cycle(1'b0, 0, '0, '1, a);
    endtask

    initial begin
        reset       = 1'b0;
        istream_val = 1'b0;
        istream_sel = '0;
        istream_msg = '0;
        ostream_rdy = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rdy", istream_rdy, 1'b1);
        chk("rst_val", ostream_val, '0);
        chk("rst_occ", occupancy, '0);
        chk("rst_err", sel_err, 1'b0);
        reset = 1'b1;

        // Basic routing
        for (int k = 0; k < NO; k++) cycle(1'b1, k, NB'(16'hA0 + k), '1, acc);
        drain();

        // Backpressure on channel 1, then channel 2 still flows
        cycle(1'b1, 1, 16'h11, 3'b101, acc);
        cycle(1'b1, 1, 16'h12, 3'b101, acc);
        cycle(1'b1, 1, 16'h13, 3'b101, acc);
        chk("bp_reject", acc, 1'b0);
        cycle(1'b1, 2, 16'h20, 3'b101, acc);
        chk("bp_other_acc", acc, 1'b1);
        drain();

        // Ordering across pointer wraps with toggling ready
        tog = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            acc = 1'b0;
            for (int t = 0; t < 10 && !acc; t++) begin
                cycle(1'b1, 0, NB'(k), {2'b11, tog}, acc);
                tog = !tog;
            end
            if (!acc) chk("wrap_send_timeout", 1'b0, 1'b1);
        end
        drain();

        // Simultaneous enqueue and dequeue at count 1
        cycle(1'b1, 2, 16'h30, 3'b011, acc);
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, 2, NB'(16'h31 + k), 3'b111, acc);
            chk("stream_acc", acc, 1'b1);
        end
        drain();

        // Out-of-range select
        cycle(1'b1, 3, 16'hFF, '1, acc);
        chk("oor_acc", acc, 1'b1);
        drain();

        // Reset mid-operation
        cycle(1'b1, 0, 16'h41, 3'b110, acc);
        cycle(1'b1, 0, 16'h42, 3'b110, acc);
        @(negedge clk);
        istream_val = 1'b0;
        istream_sel = '0;
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_val", ostream_val, '0);
        chk("mid_rst_occ", occupancy, '0);
        chk("mid_rst_rdy", istream_rdy, 1'b1);
        #1 reset = 1'b1;
        for (int i = 0; i < NO; i++) mq[i].delete();
        err_exp = 1'b0;
        cycle(1'b1, 0, 16'h55, 3'b000, acc);
        cycle(1'b0, 0, '0, 3'b000, acc);
        drain();

        // Random traffic
        for (int n = 0; n < 500; n++)
            cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                  NB'($urandom), NO'($urandom), acc);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/val_rdy_queued_demux.md
Name: val_rdy_queued_demux

Overview:
- Parametrised successor to the combinational demux: routes a val/rdy input stream to one of p_noutputs val/rdy output streams, chosen by a per-message select.
- Each output has its own p_depth-entry FIFO, so a stalled output blocks only messages addressed to it.
- Out-of-range selects are consumed and flagged.
- Sits between the router input port and the per-direction output arbiters.

Parameters:
- p_nbits, 32, message width in bits (>=1)
- p_noutputs, 4, number of output channels (>=2, need not be a power of two)
- p_depth, 2, entries per output FIFO (power of two, >=2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset; state clears immediately while low
- istream_val  in  1  input message valid
- istream_rdy  out  1  input ready
- istream_msg  in  p_nbits  input message
- istream_sel  in  $clog2(p_noutputs)  destination channel; sampled with istream_msg
- ostream_val  out  p_noutputs  per-output valid
- ostream_rdy  in  p_noutputs  per-output ready
- ostream_msg  out  p_noutputs*p_nbits  packed outputs; channel i occupies bits [i*p_nbits +: p_nbits]
- occupancy  out  p_noutputs*$clog2(p_depth+1)  packed per-FIFO entry counts
- sel_err  out  1  registered one-cycle pulse: a message with an out-of-range select was consumed

Behaviour:
- Transfer rules:
  - An input transfer occurs when istream_val && istream_rdy on a rising edge.
  - An output transfer on channel i occurs when ostream_val[i] && ostream_rdy[i].
- istream_rdy:
  - Equals !full[istream_sel] when istream_sel < p_noutputs, otherwise 1.
  - full[] is registered state. istream_rdy may depend combinationally on istream_sel, but never on istream_val or ostream_rdy.
- Latency (macro off): an accepted message is visible on ostream_msg/ostream_val of its channel on the cycle after acceptance.
- Ordering: FIFO order is preserved per channel. There is no ordering guarantee across channels.
- FIFO implementation:
  - Each FIFO uses head/tail pointers of $clog2(p_depth) bits that wrap modulo p_depth, plus a count of $clog2(p_depth+1) bits.
  - full = (count == p_depth); empty = (count == 0).
- Output drive:
  - ostream_val[i] = !empty[i].
  - ostream_msg slice i = entry at head[i].
  - When empty, the slice value is don't-care; the bench must not check it.
- Simultaneous enqueue and dequeue on the same channel:
  - count is unchanged and both pointers advance.
  - On a full FIFO, enqueue is blocked because istream_rdy is derived from the registered full; a same-cycle dequeue does not free space until the next cycle.
  - On an empty FIFO (macro off), only the enqueue happens.
- Out-of-range select (istream_sel >= p_noutputs):
  - The message is accepted and discarded.
  - sel_err is 1 on the following cycle only.
  - No FIFO state changes.
- Reset (reset low):
  - Asynchronously clears all counts, pointers and sel_err to 0.
  - ostream_val is all 0, occupancy is all 0, istream_rdy is 1.
  - FIFO storage is not reset.
  - Messages in flight at reset assertion are lost.
  - The first transfer can occur on the first rising edge after reset deasserts.
- Throughput: one input message per cycle when the target FIFO is not full. Each output can drain one message per cycle independently.

Optional Feature:
- Macro: VAL_RDY_QUEUED_DEMUX_BYPASS_EN
- Defined:
  - When the selected FIFO is empty and istream_val is high, istream_msg is driven combinationally onto that channel's ostream_msg with ostream_val high in the same cycle.
  - If ostream_rdy is also high, the message is consumed without being enqueued (zero latency, count stays 0).
  - Otherwise it is enqueued as normal.
  - In this mode istream_rdy is still independent of ostream_rdy.
- Undefined: there is no combinational path from istream_* to ostream_*, and latency is exactly 1 cycle.

Test Plan:
- Basic routing:
  - Stimulus: p_noutputs=4, all ostream_rdy=1; send 0xA0..0xA3 with sel 0..3 on consecutive cycles.
  - Response: each channel i shows 0xA0+i for one cycle, one cycle after its send; occupancy returns to 0.
- Backpressure and full:
  - Stimulus: ostream_rdy[1]=0, p_depth=2; send 0x11, 0x12, 0x13 to sel 1.
  - Response: the first two are accepted and occupancy[1]=2; istream_rdy=0 while sel=1. With sel switched to 2, istream_rdy=1 and 0x20 is delivered on channel 2.
- Order and wrap-around:
  - Stimulus: to sel 0, send 0x01..0x07 while toggling ostream_rdy[0] every cycle.
  - Response: channel 0 outputs 0x01..0x07 in order with no loss or duplication across pointer wraps.
- Simultaneous enqueue and dequeue:
  - Stimulus: hold FIFO 3 at count 1 with ostream_rdy[3]=1, and send one message per cycle to sel 3.
  - Response: occupancy[3] stays 1 and messages stream at full rate.
- Out-of-range select:
  - Stimulus: p_noutputs=3; send 0xFF with sel=3.
  - Response: istream_rdy=1, sel_err=1 for exactly the next cycle, all occupancies unchanged, and no ostream_val is asserted.
- Reset mid-operation:
  - Stimulus: fill FIFO 0 to 2 entries, then pulse reset low between clock edges.
  - Response: ostream_val=0 and occupancy=0 immediately. After release, a new message to sel 0 appears alone, with no stale data.
